// File: rtl/simd_fetch_unit.sv
// simd_fetch_unit: half-rate instruction fetch with halt detection and pipeline drain
module simd_fetch_unit #(
  parameter int OPCODE_WIDTH = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int INS_ADDR_WIDTH = 8,
  parameter int INS_DEPTH = 2**INS_ADDR_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OP = 4'hF,
  parameter int DRAIN_SLOTS = 3,
  localparam int IW = OPCODE_WIDTH + 3*ADDR_WIDTH
)(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      prog_wen,
  input  logic [INS_ADDR_WIDTH-1:0] prog_addr,
  input  logic [IW-1:0]             prog_data,
  input  logic                      start,
  output logic [IW-1:0]             instruction,
  output logic [INS_ADDR_WIDTH-1:0] pc,
  output logic                      slot,
  output logic                      busy,
  output logic                      done
);
  localparam int DW = $clog2(DRAIN_SLOTS + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam logic [INS_ADDR_WIDTH-1:0] LAST = INS_ADDR_WIDTH'(INS_DEPTH - 1);
  logic [1:0] state;
  logic phase;
  logic [INS_ADDR_WIDTH-1:0] fp;
  logic [DW-1:0] cnt;
  logic [IW-1:0] mem [INS_DEPTH];
  logic [IW-1:0] w;
  logic is_halt;
  assign w = mem[fp];
  assign is_halt = w[IW-1 -: OPCODE_WIDTH] == HALT_OP;
  assign slot = phase;
  assign busy = state == S_FETCH || state == S_DRAIN;
  assign done = state == S_DONE;
  // host programming port, only accepted while no program is running
  always_ff @(posedge clk)
    if (prog_wen && !busy) mem[prog_addr] <= prog_data;
  // control: phase toggle, fetch on slot edges, drain NOP slots, one-cycle done
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      phase <= 1'b0;
      instruction <= '0;
      pc <= '0;
      fp <= '0;
      cnt <= '0;
    end else begin
      phase <= ~phase;
      case (state)
        S_IDLE: if (start) begin
          state <= S_FETCH;
          fp <= '0;
        end
        S_FETCH: if (phase) begin
          if (is_halt) begin
            instruction <= '0;
            cnt <= DW'(DRAIN_SLOTS - 1);
            state <= S_DRAIN;
          end else begin
            instruction <= w;
            pc <= fp;
            fp <= fp + 1'b1;
            if (fp == LAST) begin
              cnt <= DW'(DRAIN_SLOTS);
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: if (phase) begin
          instruction <= '0;
          if (cnt == '0) state <= S_DONE;
          else cnt <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simd_fetch_unit.sv
// tb_simd_fetch_unit: directed run table plus random programs against a slot-level model
module tb_simd_fetch_unit;
  localparam int OW = 4, AW = 10, IAW = 8, DEPTH = 256, IW = OW + 3*AW, DS = 3;
  localparam logic [OW-1:0] HALT = 4'hF;
  logic clk = 1'b0, rstn = 1'b0, prog_wen = 1'b0, start = 1'b0;
  logic [IAW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic [IW-1:0] instruction;
  logic [IAW-1:0] pc;
  logic slot, busy, done;
  simd_fetch_unit dut (
    .clk(clk), .rstn(rstn), .prog_wen(prog_wen), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .instruction(instruction), .pc(pc), .slot(slot), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [IW-1:0] mm [DEPTH];
  bit ph = 1'b0, last_slot = 1'b0;
  int hold_pc = 0;
  typedef struct {
    string nm;
    int mode;
    int dist_j;
    int rst_slot;
    bit p0;
    int exp_n;
  } vec_t;
  vec_t tbl [8];
  // one clock: remember whether this edge was a slot edge, advance the phase model
  task automatic tick;
    @(posedge clk);
    last_slot = ph;
    ph = rstn ? ~ph : 1'b0;
    @(negedge clk);
  endtask
  task automatic chk(string nm, int j, logic [IW-1:0] ei, int ep, bit eb, bit ed);
    checks++;
    if (instruction !== ei || pc !== IAW'(ep) || busy !== eb || done !== ed || slot !== ph) begin
      errors++;
      $display("FAIL %s cyc %0d: got ins=%h pc=%0d busy=%b done=%b slot=%b want ins=%h pc=%0d busy=%b done=%b slot=%b",
               nm, j, instruction, pc, busy, done, slot, ei, IAW'(ep), eb, ed, ph);
    end
  endtask
  function automatic logic [IW-1:0] rw(logic [OW-1:0] op);
    return {op, AW'($urandom), AW'($urandom), AW'($urandom)};
  endfunction
  function automatic logic [OW-1:0] rop();
    return OW'($urandom_range(1, 14));
  endfunction
  task automatic load(int a, logic [IW-1:0] d);
    prog_wen = 1'b1;
    prog_addr = IAW'(a);
    prog_data = d;
    tick;
    prog_wen = 1'b0;
    mm[a] = d;
  endtask
  task automatic load_prog(int len);
    for (int a = 0; a < len; a++) load(a, rw(rop()));
    load(len, rw(HALT));
  endtask
  // start a program and compare every cycle until one cycle after done
  task automatic run(string nm, int dist_j, int rst_slot, bit p0, int exp_n);
    logic [IW-1:0] lst [$];
    logic [IW-1:0] w0;
    logic [IW-1:0] ei;
    int n, d0, e_done, rj, nz, e, k, ep;
    nz = 0;
    w0 = rw(rop());
    if (p0) begin
      prog_wen = 1'b1;
      prog_addr = '0;
      prog_data = w0;
      mm[0] = w0;
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (mm[a][IW-1 -: OW] === HALT) break;
      lst.push_back(mm[a]);
    end
    n = lst.size();
    start = 1'b1;
    tick;
    start = 1'b0;
    prog_wen = 1'b0;
    d0 = last_slot ? 2 : 1;
    e_done = d0 + 2*n + 2*DS;
    rj = rst_slot >= 0 ? d0 + 2*rst_slot : -1;
    for (int j = 0; j <= e_done + 1; j++) begin
      e = j - d0;
      k = e >= 0 ? e / 2 : -1;
      ei = (k >= 0 && k < n) ? lst[k] : '0;
      ep = (k >= 0 && k < n) ? k : (k >= n && n > 0) ? n - 1 : hold_pc;
      chk(nm, j, ei, ep, j < e_done, j == e_done);
      if (instruction != '0) nz++;
      if (j == rj) begin
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        hold_pc = 0;
        chk({nm, "_rst"}, j, '0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
          tick;
          chk({nm, "_post"}, i, '0, 0, 1'b0, 1'b0);
        end
        return;
      end
      if (j == dist_j) begin
        start = 1'b1;
        prog_wen = 1'b1;
        prog_addr = 8'd5;
        prog_data = rw(rop());
      end
      if (j <= e_done) begin
        tick;
        start = 1'b0;
        prog_wen = 1'b0;
      end
    end
    if (n > 0) hold_pc = n - 1;
    if (exp_n >= 0) begin
      checks++;
      if (nz / 2 != exp_n) begin
        errors++;
        $display("FAIL %s issued: got %0d want %0d", nm, nz / 2, exp_n);
      end
    end
  endtask
  initial begin
    tbl = '{
      '{"add_mul_dot",   0, -1, -1, 1'b0,   3},
      '{"halt_first",    1, -1, -1, 1'b0,   0},
      '{"full_mem",      2, -1, -1, 1'b0, 256},
      '{"busy_ignore",   3,  4, -1, 1'b0,   8},
      '{"rerun",         4, -1, -1, 1'b0,   8},
      '{"reset_mid",     3, -1,  2, 1'b0,  -1},
      '{"after_reset",   4, -1, -1, 1'b0,   8},
      '{"prog_start",    4, -1, -1, 1'b1,   8}
    };
    tick;
    tick;
    rstn = 1'b1;
    chk("reset", 0, '0, 0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      case (tbl[i].mode)
        0: begin
          load(0, rw(4'h1));
          load(1, rw(4'h2));
          load(2, rw(4'h3));
          load(3, rw(HALT));
        end
        1: load(0, rw(HALT));
        2: for (int a = 0; a < DEPTH; a++) load(a, rw(4'h1));
        3: load_prog(8);
        default: ;
      endcase
      run(tbl[i].nm, tbl[i].dist_j, tbl[i].rst_slot, tbl[i].p0, tbl[i].exp_n);
    end
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(0, 12);
      load_prog(len);
      for (int i = $urandom_range(0, 3); i > 0; i--) tick;
      run("random", $urandom_range(0, 1) ? int'($urandom_range(1, 6)) : -1, -1, 1'(r % 3 == 0), len);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
